// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath: byte width, header field
// positions, packet counter width and default output buffer depth.
package router_pkg;

  localparam int BYTE_W       = 8;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  localparam int PKT_CNT_W    = 6;

  localparam int FIFO_DEPTH   = 16;

endpackage : router_pkg

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router. Stores {header tag, byte}
// words and replays them to the reader; a header-loaded byte counter frames
// each packet so data_out returns to 0 once a packet has fully drained.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     read_enb,
  input  logic                     lfd_state,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]         mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [PKT_CNT_W-1:0]   pkt_cnt;
  logic [WIDTH:0]         rd_word;
  logic                   clr;
  logic                   wr_acc;
  logic                   rd_acc;

  // Flags come straight from the registered pointers; the extra MSB
  // distinguishes full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;

  assign clr     = reset | soft_reset;
  assign wr_acc  = write_enb & ~full;
  assign rd_acc  = read_enb & ~empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are left alone on reset, only pointers are cleared.
  always_ff @(posedge clock) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Write and read pointers, wrapping naturally through 2*DEPTH.
  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Packet framing counter and registered read data with idle-to-zero.
  always_ff @(posedge clock) begin
    if (clr) begin
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= rd_word[WIDTH-1:0];
      if (rd_word[WIDTH]) begin
        // header: payload length plus the trailing parity byte
        pkt_cnt <= PKT_CNT_W'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
      end else if (pkt_cnt != '0) begin
        pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
      end
    end else if (pkt_cnt == '0) begin
      data_out <= '0;
    end
  end

endmodule : router_fifo

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer and its packet framing.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  int         m_cnt  = 0;
  logic [7:0] m_dout = 8'h00;
  int         wr_count = 0;
  int         rd_count = 0;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then compare.
  task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] d,
                      input bit rs = 1'b0, input bit srs = 1'b0);
    bit m_full, m_empty, rd, wr;
    logic [8:0] w;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = d;
    reset      = rs;
    soft_reset = srs;
    @(posedge clock);
    if (rs || srs) begin
      q.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
    end else begin
      m_full  = (q.size() == 16);
      m_empty = (q.size() == 0);
      rd = re && !m_empty;
      wr = we && !m_full;
      if (rd) begin
        w = q.pop_front();
        m_dout = w[7:0];
        rd_count++;
        if (w[8]) m_cnt = ((int'(w[7:0]) / 4) + 1) % 64;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (wr) begin
        q.push_back({lfd, d});
        wr_count++;
      end
    end
    #1;
    chk("data_out", int'(data_out), int'(m_dout));
    chk("level", int'(level), q.size());
    chk("full", int'(full), int'(q.size() == 16));
    chk("empty", int'(empty), int'(q.size() == 0));
  endtask

  logic [7:0] pkt[7];
  logic [7:0] last_b;
  int         lvl_before;
  int         wr0;

  initial begin
    // Reset state
    step(0, 0, 0, 8'h00, 1'b1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_level", int'(level), 0);

    // Single packet: header 0x15 (len 5, addr 1), 5 payload, parity
    pkt[0] = 8'h15;
    for (int i = 1; i < 7; i++) pkt[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 7; i++) step(1, 0, (i == 0), pkt[i]);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 8'h00);
      chk("pkt_byte", int'(data_out), int'(pkt[i]));
    end
    step(0, 0, 0, 8'h00);
    chk("pkt_idle_zero", int'(data_out), 0);

    // Fill to 16 with a long header so the counter stays nonzero, overflow write
    step(1, 0, 1, 8'h52);
    for (int i = 1; i < 16; i++) step(1, 0, 0, 8'($urandom));
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    step(1, 0, 0, 8'hAA);
    chk("drop_level", int'(level), 16);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    chk("drain_empty", int'(empty), 1);
    last_b = data_out;
    step(0, 1, 0, 8'h00);
    chk("rd17_hold", int'(data_out), int'(last_b));
    step(0, 0, 0, 8'h00, 1'b1);

    // Steady simultaneous stream at level 8
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'($urandom));
    wr0 = wr_count;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, ($urandom_range(0, 7) == 0), 8'($urandom));
      chk("stream_level", int'(level), 8);
    end
    chk("stream_writes", wr_count - wr0, 40);

    // Full with both requests: only the read goes through
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'($urandom));
    chk("both_pre_full", int'(full), 1);
    step(1, 1, 0, 8'hEE);
    chk("both_level", int'(level), 15);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00, 1'b1);

    // Soft reset mid-packet after 3 of 7 bytes read
    for (int i = 0; i < 7; i++) step(1, 0, (i == 0), (i == 0) ? 8'h15 : 8'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00, 1'b0, 1'b1);
    chk("srst_empty", int'(empty), 1);
    chk("srst_level", int'(level), 0);
    chk("srst_dout", int'(data_out), 0);
    pkt[0] = 8'h16;
    for (int i = 1; i < 7; i++) pkt[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 7; i++) step(1, 0, (i == 0), pkt[i]);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 8'h00);
      chk("post_srst_byte", int'(data_out), int'(pkt[i]));
    end
    step(0, 0, 0, 8'h00);

    // Reset together with a write on a non-empty buffer
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'($urandom));
    step(1, 0, 0, 8'h77, 1'b1);
    chk("rst_wr_level", int'(level), 0);
    chk("rst_wr_empty", int'(empty), 1);
    step(0, 1, 0, 8'h00);
    chk("rst_wr_discard", int'(data_out), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0), 8'($urandom), 1'b0,
           ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_router_fifo
